mem_arbiter: RTL and testbench

Parametrised memory front-end that sits between one or more requesters (the multicycle RISC-V core's data port, an instruction-fetch port, a debug/DMA port) and the single-port unified memory. Grants one request at a time by round-robin, handles RV32I byte/half/word lanes from `funct3` (write byte enables, read sign/zero extension), adds configurable memory wait states, and flags misaligned or illegal accesses instead of issuing them.

---
 rtl/mem_arbiter_pkg.sv | 44 ++++
 rtl/mem_arbiter_rr_arbiter.sv | 46 ++++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory front-end: RV32I load/store funct3
// encodings, the controller state type and the access legality rule.
package mem_arbiter_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Largest supported number of extra memory cycles per access
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // An access is legal when its funct3 exists for that direction and the
  // address is naturally aligned for the access size.
  function automatic logic access_legal(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~addr_lo[0];
      3'b010:  ok = (addr_lo == 2'b00);
      3'b100:  ok = ~write;
      3'b101:  ok = ~write & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches for a requester starting one past the most
// recently granted port and grants exactly one of them while enabled.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic          found;
  int            grant_idx;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    grant     = '0;
    found     = 1'b0;
    grant_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[(int'(ptr) + i) % N]) begin
        found                      = 1'b1;
        grant_idx                  = (int'(ptr) + i) % N;
        grant[(int'(ptr) + i) % N] = 1'b1;
      end
    end
  end

  // Advance the pointer past the winner on every accepted grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so that every
      // flop samples its inputs from the same pre-edge values.
      ptr <= '0;
    end else if (found) begin
      ptr <= IW'((grant_idx + 1) % N);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory front-end: round-robin grant of one requester at a time, RV32I
// byte/half/word lane handling, configurable wait states, and error
// responses for misaligned or illegal accesses that never reach memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  output logic [NUM_PORTS-1:0]    req_ready,
  input  logic [NUM_PORTS-1:0]    req_write,
  input  logic [NUM_PORTS*3-1:0]  req_funct3,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [ADDR_W-3:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t state, state_nx;

  logic [NUM_PORTS-1:0] grant;
  logic                 accept;

  // Request selected by the arbiter this cycle
  logic [IDX_W-1:0]  sel_port;
  logic              sel_write;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_legal;

  // Request latched at the handshake
  logic [IDX_W-1:0]  port_q;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [3:0]        wait_q;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (state == S_IDLE),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Mux the granted port's request fields.
  always_comb begin
    sel_port  = '0;
    sel_write = 1'b0;
    sel_f3    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_port  = IDX_W'(i);
        sel_write = req_write[i];
        sel_f3    = req_funct3[3*i +: 3];
        sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
    sel_legal = access_legal(sel_write, sel_f3, sel_addr[1:0]);
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state: illegal requests skip ACCESS; legal ones stay WAIT_STATES+1 cycles.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = sel_legal ? S_ACCESS : S_RESP;
      S_ACCESS: if (wait_q == 4'd0) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Latch the accepted request and count down the wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q  <= '0;
      write_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else if (state == S_IDLE && accept) begin
      port_q  <= sel_port;
      write_q <= sel_write;
      f3_q    <= sel_f3;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      err_q   <= ~sel_legal;
      wait_q  <= WAIT_INIT;
    end else if (state == S_ACCESS && wait_q != 4'd0) begin
      wait_q <= wait_q - 4'd1;
    end
  end

  // Memory side: drive the latched access only while in ACCESS; the write
  // strobe fires once, in the first ACCESS cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == S_ACCESS) begin
      mem_addr = addr_q[ADDR_W-1:2];
      if (write_q) begin
        mem_we = (wait_q == WAIT_INIT);
        case (f3_q)
          SB: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          SH: begin
            mem_be    = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end
    end
  end

  // Response side: the memory's output register holds the word addressed in
  // the last ACCESS cycle, so RESP extracts and extends lanes from it directly.
  always_comb begin
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (addr_q[1:0])
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (state == S_RESP) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rsp_valid[i] = (port_q == IDX_W'(i));
      end
      rsp_err = err_q;
      if (!err_q && !write_q) begin
        case (f3_q)
          LB:      rsp_rdata = {{24{rd_byte[7]}}, rd_byte};
          LH:      rsp_rdata = {{16{rd_half[15]}}, rd_half};
          LW:      rsp_rdata = mem_rdata;
          LBU:     rsp_rdata = {24'd0, rd_byte};
          LHU:     rsp_rdata = {16'd0, rd_half};
          default: rsp_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: one instance with no wait states and
// one with three, each backed by a small synchronous-read memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NP = 2;
  localparam int AW = 32;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  be;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst        [2];
  logic [NP-1:0]     req_valid  [2];
  logic [NP-1:0]     req_ready  [2];
  logic [NP-1:0]     req_write  [2];
  logic [3*NP-1:0]   req_funct3 [2];
  logic [AW*NP-1:0]  req_addr   [2];
  logic [32*NP-1:0]  req_wdata  [2];
  logic [NP-1:0]     rsp_valid  [2];
  logic [31:0]       rsp_rdata  [2];
  logic              rsp_err    [2];
  logic              mem_we     [2];
  logic [3:0]        mem_be     [2];
  logic [AW-3:0]     mem_addr   [2];
  logic [31:0]       mem_wdata  [2];
  logic [31:0]       mem_rdata  [2];
  logic [31:0]       mem        [2][64];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Byte-enabled write, registered read of the presented word address.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[g] && mem_be[g][b]) mem[g][mem_addr[g][5:0]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
      mem_rdata[g] <= mem[g][mem_addr[g][5:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input int port, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    req_valid[inst][port]            = 1'b1;
    req_write[inst][port]            = wr;
    req_funct3[inst][3*port +: 3]    = f3;
    req_addr[inst][AW*port +: AW]    = addr;
    req_wdata[inst][32*port +: 32]   = wd;
  endtask

  // One complete transaction: push the expectation, handshake, then pop and
  // compare when the response pulse arrives.
  task automatic do_access(input int inst, input int port, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic [3:0] exp_be, input string tag);
    exp_t        e;
    int          hs_cyc;
    bit          got;
    logic        we1, we_seen;
    logic [3:0]  be1;
    e.port  = port;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_err ? 1 : 2 + ((inst == 1) ? 3 : 0);
    e.be    = exp_be;
    e.we    = wr & ~exp_err;
    sb.push_back(e);
    @(negedge clk);
    drive(inst, port, wr, f3, addr, wd);
    #1;
    got    = 1'b0;
    hs_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready[inst][port]) begin
        got    = 1'b1;
        hs_cyc = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    check({tag, "_grant"}, 32'(got), 32'd1);
    if (!got) begin
      req_valid[inst][port] = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    we1     = mem_we[inst];
    be1     = mem_be[inst];
    we_seen = we1;
    req_valid[inst][port] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid[inst] != '0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      we_seen = we_seen | mem_we[inst];
    end
    e = sb.pop_front();
    check({tag, "_rsp"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_lat"},   32'(cyc - hs_cyc), 32'(e.lat));
      check({tag, "_port"},  32'(rsp_valid[inst]), 32'(1 << e.port));
      check({tag, "_rdata"}, rsp_rdata[inst], e.rdata);
      check({tag, "_err"},   32'(rsp_err[inst]), 32'(e.err));
    end
    check({tag, "_we"}, 32'(we1), 32'(e.we));
    check({tag, "_be"}, 32'(be1), 32'(e.be));
    if (e.err) check({tag, "_we_never"}, 32'(we_seen), 32'd0);
  endtask

  initial begin
    int   gseq [4];
    int   n;
    bit   two;
    bit   seen;
    bit   got;

    for (int i = 0; i < 2; i++) begin
      rst[i]        = 1'b0;
      req_valid[i]  = '0;
      req_write[i]  = '0;
      req_funct3[i] = '0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);

    // Reset values on both instances
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      check("rst_rsp_err",   32'(rsp_err[i]), 32'd0);
      check("rst_mem_we",    32'(mem_we[i]), 32'd0);
      check("rst_mem_be",    32'(mem_be[i]), 32'd0);
      check("rst_mem_addr",  32'(mem_addr[i]), 32'd0);
      check("rst_mem_wdata", mem_wdata[i], 32'd0);
    end

    // No wait states: word, byte and half lanes plus extension
    do_access(0, 0, 1'b1, SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, "sw10");
    do_access(0, 0, 1'b0, LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, "lw10");
    do_access(0, 0, 1'b1, SB,  32'h13, 32'h00000080, 32'h0,        1'b0, 4'b1000, "sb13");
    do_access(0, 0, 1'b0, LB,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, "lb13");
    do_access(0, 0, 1'b0, LBU, 32'h13, 32'h0,        32'h00000080, 1'b0, 4'b0000, "lbu13");
    do_access(0, 0, 1'b1, SH,  32'h12, 32'h00001234, 32'h0,        1'b0, 4'b1100, "sh12");
    do_access(0, 0, 1'b0, LH,  32'h12, 32'h0,        32'h00001234, 1'b0, 4'b0000, "lh12");
    do_access(0, 0, 1'b0, LH,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 4'b0000, "lh10");
    do_access(0, 0, 1'b0, LBU, 32'h10, 32'h0,        32'h000000EF, 1'b0, 4'b0000, "lbu10");

    // Illegal and misaligned accesses
    do_access(0, 0, 1'b0, LH,     32'h11, 32'h0,        32'h0, 1'b1, 4'b0000, "lh11_err");
    do_access(0, 0, 1'b0, 3'b011, 32'h00, 32'h0,        32'h0, 1'b1, 4'b0000, "f3_011_err");
    do_access(0, 0, 1'b1, 3'b100, 32'h10, 32'h0,        32'h0, 1'b1, 4'b0000, "st_100_err");
    do_access(0, 1, 1'b1, SW,     32'h02, 32'h11111111, 32'h0, 1'b1, 4'b0000, "sw02_err");
    do_access(0, 0, 1'b0, LW,     32'h10, 32'h0, 32'h1234BEEF, 1'b0, 4'b0000, "lw10_after_err");
    do_access(0, 1, 1'b0, LW,     32'h10, 32'h0, 32'h1234BEEF, 1'b0, 4'b0000, "lw10_p1");

    // Both ports requesting continuously: grants alternate starting at port 0
    @(negedge clk);
    drive(0, 0, 1'b0, LW, 32'h10, 32'h0);
    drive(0, 1, 1'b0, LW, 32'h10, 32'h0);
    n   = 0;
    two = 1'b0;
    for (int i = 0; i < 4; i++) gseq[i] = -1;
    for (int k = 0; k < 60 && n < 4; k++) begin
      #1;
      if ($countones(req_ready[0]) > 1) two = 1'b1;
      if (req_ready[0] == 2'b01) begin
        gseq[n] = 0;
        n++;
      end else if (req_ready[0] == 2'b10) begin
        gseq[n] = 1;
        n++;
      end
      @(negedge clk);
    end
    req_valid[0] = '0;
    check("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) check("rr_order", 32'(gseq[i]), 32'(i % 2));
    check("rr_onehot", 32'(two), 32'd0);
    repeat (6) @(negedge clk);

    // Three wait states
    do_access(1, 0, 1'b1, SW,  32'h10, 32'h80010000, 32'h0,        1'b0, 4'b1111, "w3_sw10");
    do_access(1, 0, 1'b0, LHU, 32'h12, 32'h0,        32'h00008001, 1'b0, 4'b0000, "w3_lhu12");
    do_access(1, 1, 1'b0, LH,  32'h12, 32'h0,        32'hFFFF8001, 1'b0, 4'b0000, "w3_lh12");
    do_access(1, 0, 1'b0, LW,  32'h13, 32'h0,        32'h0,        1'b1, 4'b0000, "w3_lw13_err");

    // Reset asserted during the ACCESS phase of a store
    @(negedge clk);
    drive(1, 0, 1'b1, SW, 32'h20, 32'h55555555);
    #1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready[1][0]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("rmid_grant", 32'(got), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rmid_we_before", 32'(mem_we[1]), 32'd1);
    rst[1] = 1'b0;
    #1;
    check("rmid_we",        32'(mem_we[1]), 32'd0);
    check("rmid_be",        32'(mem_be[1]), 32'd0);
    check("rmid_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    req_valid[1] = '0;
    repeat (2) @(negedge clk);
    rst[1] = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1] != '0 || mem_we[1]) seen = 1'b1;
    end
    check("rmid_no_rsp", 32'(seen), 32'd0);
    do_access(1, 1, 1'b0, LW, 32'h10, 32'h0, 32'h80010000, 1'b0, 4'b0000, "w3_lw_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
